wgp_seq_ctrl: RTL and testbench
===============================

// Module: wgp_seq_ctrl
// PURPOSE
//   Sequencer for the waveform generator datapath. Holds a small program of entries (waveform func, rate divisor, period count).
//   Plays the entries in order: drives func and the 8-bit phase count_num into the generator and steps to the next entry after the programmed number of phase periods.
//   Sits between the board-level control (switches/buttons) and the waveform generator.
// PARAMETERS
//   DEPTH  8   program entries; power of 2, 2..16
//   DIV_W  16  width of rate divisor; phase advances once every (div+1) clk
//   DUR_W  8   width of period count; one period = 256 phase steps
// PORTS
//   clk        in   1      system clock, all logic on rising edge
//   rst        in   1      asynchronous, active-high reset
//   cfg_we     in   1      program write strobe; honoured only when busy=0
//   cfg_addr   in   log2(DEPTH)  entry index to write
//   cfg_func   in   3      waveform select stored in entry
//   cfg_div    in   DIV_W  rate divisor stored in entry
//   cfg_dur    in   DUR_W  periods to play; 0 = skip entry
//   cfg_last   in   1      entry ends the program
//   start      in   1      one-cycle pulse: begin at entry 0
//   stop       in   1      one-cycle pulse: abort to IDLE
//   loop_en    in   1      at program end restart at entry 0 instead of DONE
//   func       out  3      waveform select to generator; 3'b111 (muted) when not RUN
//   count_num  out  8      phase count to generator
//   step       out  1      1-cycle pulse when count_num advances
//   entry_idx  out  log2(DEPTH)  entry currently loaded/playing
//   busy       out  1      1 in LOAD or RUN
//   done       out  1      1-cycle pulse on entering DONE
// BEHAVIOUR
//   Reset: state=IDLE, func=3'b111, count_num=0, step=0, entry_idx=0, busy=0, done=0, prescaler=0, period counter=0.
//     Program memory is not reset.
//   FSM IDLE -> LOAD on start. LOAD -> RUN when the entry has dur!=0. LOAD -> advance when dur==0.
//     RUN -> advance when the period counter expires. Advance: if cfg_last of the entry or entry_idx==DEPTH-1:
//     loop_en ? (idx=0, LOAD) : DONE; else (idx+1, LOAD). DONE -> IDLE after 1 cycle.
//     An all-skip program with loop_en=1 cycles in LOAD indefinitely; only stop exits.
//   Latency: start sampled at edge N -> LOAD at N+1 -> RUN at N+2. func = entry func and count_num=0 from N+2.
//   LOAD: 1 cycle. Latches div/dur/func of entry_idx. Clears prescaler, count_num and period counter.
//   RUN: prescaler counts 0..div. At div it wraps to 0, step=1, count_num+1 (mod 256). div=0 -> step every cycle.
//     Each count_num 255->0 wrap increments the period counter. When the counter reaches dur, advance on that same edge.
//     The entry therefore plays exactly dur*256*(div+1) cycles.
//   stop has priority over everything: at the next edge state=IDLE, func=3'b111, count_num=0, busy=0, no done pulse.
//   start while busy: ignored. start and stop in the same cycle: stop wins.
//   cfg_we while busy: ignored, program unchanged. cfg_we and start in the same cycle from IDLE: write lands, then start sees the new entry.
//   Async rst mid-RUN: all outputs return to reset values immediately. No partial done.
//   Outputs are registered. Arithmetic is unsigned. The period counter is DUR_W bits and never wraps, since it is compared for equality before overflow.
// STRUCTURE
//   Package wgp_pkg: func encodings (RHOMBOID=0, SQUARE=1, RECIP=2, TRIANGLE=3, FWR=4, HWR=5, SMSW=6, MUTE=7) and a state enum.
//   Sub-module wgp_prescaler: DIV_W-bit divider. Inputs clk, rst, clr, en, div. Output tick.
//   Program memory is a register array in this module (DEPTH x (3+DIV_W+DUR_W+1)).
// TESTING
//   Reset then idle 20 cycles -> func=7, count_num=0, busy=0, step never 1.
//   Entry0 {func=1, div=0, dur=1, last=1}, start -> RUN 2 cycles after start, 256 steps, done pulse at cycle 258, func back to 7.
//   Entry0 {3, div=2, dur=1}, entry1 {4, div=0, dur=2, last=1} -> steps every 3 clk in entry0; entry_idx=1 after 768 cycles + LOAD; entry1 lasts 512 cycles.
//   Entry0 dur=0, entry1 {6, div=0, dur=1, last=1} -> entry0 skipped in 1 LOAD cycle, RUN entry1 with func=6.
//   loop_en=1 on one-entry program -> no done; entry_idx returns to 0; LOAD cycle every 257 clk; stop mid-RUN -> IDLE next edge, no done.
//   cfg_we during RUN with new func -> playback unchanged; async rst asserted mid-RUN -> outputs at reset values before next clk edge.

Source files
------------

// File: rtl/wgp_pkg.sv
// Shared encodings for the waveform generator sequencer: generator function
// selects and sequencer FSM states.
package wgp_pkg;

  typedef enum logic [2:0] {
    RHOMBOID = 3'd0,
    SQUARE   = 3'd1,
    RECIP    = 3'd2,
    TRIANGLE = 3'd3,
    FWR      = 3'd4,
    HWR      = 3'd5,
    SMSW     = 3'd6,
    MUTE     = 3'd7
  } wgp_func_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } wgp_state_e;

endpackage

// File: rtl/wgp_prescaler.sv
// Rate divider: counts 0..div while enabled and flags the wrap cycle with tick,
// giving one tick every (div+1) enabled clocks.
module wgp_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/wgp_seq_ctrl.sv
// Waveform generator sequencer: plays a small program of {func, div, dur, last}
// entries, driving func and the phase count into the generator.
module wgp_seq_ctrl
  import wgp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DIV_W = 16,
  parameter int DUR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [2:0]               cfg_func,
  input  logic [DIV_W-1:0]         cfg_div,
  input  logic [DUR_W-1:0]         cfg_dur,
  input  logic                     cfg_last,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  output logic [2:0]               func,
  output logic [7:0]               count_num,
  output logic                     step,
  output logic [$clog2(DEPTH)-1:0] entry_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]       func;
    logic [DIV_W-1:0] div;
    logic [DUR_W-1:0] dur;
    logic             last;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           rd;
  entry_t           cur;
  wgp_state_e       state_q, state_d;
  logic [AW-1:0]    idx_d;
  logic [DUR_W-1:0] per_q;
  logic             tick, wrap, period_end, is_last, prog_end, adv;

  assign rd = mem[entry_idx];

  always_ff @(posedge clk) begin
    if (cfg_we && state_q != ST_LOAD && state_q != ST_RUN)
      mem[cfg_addr] <= '{func: cfg_func, div: cfg_div, dur: cfg_dur, last: cfg_last};
  end

  wgp_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state_q != ST_RUN) || stop),
    .en   (state_q == ST_RUN),
    .div  (cur.div),
    .tick (tick)
  );

  // The period counter is compared one step ahead so it never needs to hold dur+1.
  assign wrap       = tick && (count_num == 8'hFF);
  assign period_end = wrap && ((per_q + DUR_W'(1)) == cur.dur);
  assign is_last    = (state_q == ST_LOAD) ? rd.last : cur.last;
  assign prog_end   = is_last || (entry_idx == AW'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = entry_idx;
    adv     = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_LOAD;
        idx_d   = '0;
      end
      ST_LOAD: if (rd.dur == '0) adv = 1'b1;
               else state_d = ST_RUN;
      ST_RUN:  if (period_end) adv = 1'b1;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (adv) begin
      if (prog_end) begin
        if (loop_en) begin
          idx_d   = '0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_DONE;
        end
      end else begin
        idx_d   = entry_idx + AW'(1);
        state_d = ST_LOAD;
      end
    end
    if (stop) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      entry_idx <= '0;
      cur       <= '0;
      per_q     <= '0;
      func      <= MUTE;
      count_num <= '0;
      step      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      entry_idx <= idx_d;
      if (state_q == ST_LOAD) cur <= rd;
      func <= (state_d == ST_RUN) ? ((state_q == ST_LOAD) ? rd.func : cur.func) : MUTE;
      busy <= (state_d == ST_LOAD) || (state_d == ST_RUN);
      done <= (state_d == ST_DONE) && (state_q != ST_DONE);
      step <= tick && !stop;
      if (state_q != ST_RUN || stop) count_num <= '0;
      else if (tick)                 count_num <= count_num + 8'd1;
      if (state_q != ST_RUN) per_q <= '0;
      else if (wrap)         per_q <= per_q + DUR_W'(1);
    end
  end

endmodule

// File: tb/tb_wgp_seq_ctrl.sv
// Directed bench for wgp_seq_ctrl: hand-computed cycle positions of LOAD/RUN,
// steps and done relative to the start pulse (start edge = cycle 1 visible).
module tb_wgp_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [2:0]  cfg_func;
  logic [15:0] cfg_div;
  logic [7:0]  cfg_dur;
  logic        cfg_last;
  logic        start, stop, loop_en;
  logic [2:0]  func;
  logic [7:0]  count_num;
  logic        step;
  logic [2:0]  entry_idx;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc, nsteps, done_cyc, steps_seen;

  wgp_seq_ctrl #(.DEPTH(8), .DIV_W(16), .DUR_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_func(cfg_func), .cfg_div(cfg_div), .cfg_dur(cfg_dur),
    .cfg_last(cfg_last), .start(start), .stop(stop), .loop_en(loop_en),
    .func(func), .count_num(count_num), .step(step), .entry_idx(entry_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clk1();
    @(posedge clk); #1;
    cyc++;
    if (step) nsteps++;
    if (done && done_cyc == 0) done_cyc = cyc;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) clk1();
  endtask

  task automatic wait_done(input int budget);
    while (done_cyc == 0 && cyc < budget) clk1();
  endtask

  task automatic set_cfg(input logic [2:0] a, input logic [2:0] f, input logic [15:0] d,
                         input logic [7:0] n, input logic l);
    cfg_addr = a; cfg_func = f; cfg_div = d; cfg_dur = n; cfg_last = l;
  endtask

  task automatic wr(input logic [2:0] a, input logic [2:0] f, input logic [15:0] d,
                    input logic [7:0] n, input logic l);
    set_cfg(a, f, d, n, l);
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; nsteps = 0; done_cyc = 0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 0; start = 0; stop = 0; loop_en = 0;
    set_cfg(0, 0, 0, 0, 0);
    cyc = 0; nsteps = 0; done_cyc = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset and idle
    check("rst_func", func, 7);
    check("rst_count", count_num, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", entry_idx, 0);
    steps_seen = 0;
    repeat (20) begin clk1(); if (step) steps_seen++; end
    check("idle_steps", steps_seen, 0);
    check("idle_func", func, 7);

    // single entry, div=0, dur=1
    wr(0, 1, 0, 1, 1);
    pulse_start();
    check("t1_load_busy", busy, 1);
    check("t1_load_func", func, 7);
    run_to(2);
    check("t1_run_func", func, 1);
    check("t1_run_count", count_num, 0);
    run_to(3);
    check("t1_first_step", step, 1);
    check("t1_count1", count_num, 1);
    wait_done(400);
    check("t1_done_cyc", done_cyc, 258);
    check("t1_steps", nsteps, 256);
    check("t1_done_func", func, 7);
    clk1();
    check("t1_done_pulse", done, 0);
    check("t1_idle_busy", busy, 0);

    // two entries, div=2 then div=0 dur=2
    wr(0, 3, 2, 1, 0);
    wr(1, 4, 0, 2, 1);
    pulse_start();
    run_to(4);
    check("t2_no_step4", step, 0);
    run_to(5);
    check("t2_step5", step, 1);
    check("t2_count5", count_num, 1);
    run_to(769);
    check("t2_idx769", entry_idx, 0);
    check("t2_count769", count_num, 255);
    run_to(770);
    check("t2_idx770", entry_idx, 1);
    check("t2_load_func", func, 7);
    run_to(771);
    check("t2_func771", func, 4);
    wait_done(2000);
    check("t2_done_cyc", done_cyc, 1283);
    check("t2_steps", nsteps, 768);
    clk1();

    // skipped entry; entry1 written in the same cycle as start
    wr(0, 5, 0, 0, 0);
    set_cfg(1, 6, 0, 1, 1);
    cfg_we = 1'b1;
    pulse_start();
    cfg_we = 1'b0;
    check("t3_idx_c1", entry_idx, 0);
    run_to(2);
    check("t3_idx_c2", entry_idx, 1);
    check("t3_busy_c2", busy, 1);
    check("t3_func_c2", func, 7);
    run_to(3);
    check("t3_func_c3", func, 6);
    wait_done(600);
    check("t3_done_cyc", done_cyc, 259);
    clk1();

    // looping one-entry program, then stop
    wr(0, 2, 0, 1, 1);
    loop_en = 1'b1;
    pulse_start();
    run_to(258);
    check("t4_reload_busy", busy, 1);
    check("t4_reload_func", func, 7);
    check("t4_reload_idx", entry_idx, 0);
    run_to(259);
    check("t4_func259", func, 2);
    run_to(515);
    check("t4_func515", func, 7);
    run_to(600);
    check("t4_count600", count_num, 84);
    stop = 1'b1;
    clk1();
    stop = 1'b0;
    check("t4_stop_busy", busy, 0);
    check("t4_stop_func", func, 7);
    check("t4_stop_count", count_num, 0);
    repeat (5) clk1();
    check("t4_no_done", done_cyc, 0);
    loop_en = 1'b0;

    // start and stop together: stop wins
    start = 1'b1; stop = 1'b1;
    clk1();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", busy, 0);

    // write and start ignored while running
    wr(0, 5, 0, 1, 1);
    pulse_start();
    run_to(10);
    set_cfg(0, 1, 0, 3, 1);
    cfg_we = 1'b1;
    clk1();
    cfg_we = 1'b0;
    run_to(20);
    start = 1'b1;
    clk1();
    start = 1'b0;
    run_to(22);
    check("t5_count22", count_num, 20);
    check("t5_func22", func, 5);
    wait_done(600);
    check("t5_done_cyc", done_cyc, 258);
    clk1();
    pulse_start();
    run_to(2);
    check("t5_prog_kept", func, 5);

    // async reset mid-RUN
    run_to(50);
    #2 rst = 1'b1;
    #1;
    check("ar_func", func, 7);
    check("ar_count", count_num, 0);
    check("ar_busy", busy, 0);
    check("ar_idx", entry_idx, 0);
    #4 rst = 1'b0;
    clk1();
    check("ar_after_busy", busy, 0);
    check("ar_after_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
